// File: rtl/compress_pkg.sv
// Shared types and control-code constants for the stream-compression sequencer.
package compress_pkg;

    localparam int FIRST_FREE_DEF = 257;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_HASH,
        S_PROBE,
        S_EMIT,
        S_INSERT,
        S_CLEAR,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [6:0] C_IDLE   = 7'h00;
    localparam logic [6:0] C_FIRST  = 7'h01;
    localparam logic [6:0] C_LOAD   = 7'h02;
    localparam logic [6:0] C_HASH   = 7'h03;
    localparam logic [6:0] C_PROBE  = 7'h04;
    localparam logic [6:0] C_EMIT   = 7'h05;
    localparam logic [6:0] C_INSERT = 7'h06;
    localparam logic [6:0] C_CLEAR  = 7'h07;
    localparam logic [6:0] C_FLUSH  = 7'h08;

    // The first symbol of a block seeds the prefix register instead of extending it.
    function automatic logic [6:0] code_of(input state_t s, input logic first);
        logic [6:0] c;
        c = C_IDLE;
        case (s)
            S_LOAD:   c = first ? C_FIRST : C_LOAD;
            S_HASH:   c = C_HASH;
            S_PROBE:  c = C_PROBE;
            S_EMIT:   c = C_EMIT;
            S_INSERT: c = C_INSERT;
            S_CLEAR:  c = C_CLEAR;
            S_FLUSH:  c = C_FLUSH;
            default:  c = C_IDLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/compress_dict_cnt.sv
// Next-free dictionary index: saturating increment, clear back to the first free entry.
module compress_dict_cnt
    import compress_pkg::*;
#(
    parameter int DICT_W     = 12,
    parameter int FIRST_FREE = FIRST_FREE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              clr,
    output logic [DICT_W-1:0] cnt,
    output logic              at_max
);

    assign at_max = &cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= DICT_W'(FIRST_FREE);
        end else if (clr) begin
            cnt <= DICT_W'(FIRST_FREE);
        end else if (inc && !at_max) begin
            cnt <= cnt + DICT_W'(1);
        end
    end

endmodule

// File: rtl/compress_seq.sv
// Per-symbol sequencer: load, hash, probe, emit, insert; drives the datapath control code.
module compress_seq
    import compress_pkg::*;
#(
    parameter int CODE_W     = 7,
    parameter int DICT_W     = 12,
    parameter int FIRST_FREE = FIRST_FREE_DEF,
    parameter int PROBE_MAX  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              lk_done,
    input  logic              lk_hit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] ctl_code,
    output logic [DICT_W-1:0] dict_cnt,
    output logic              busy,
    output logic              done
);

    state_t     state, nxt;
    logic [3:0] probe_cnt, probe_nxt;
    logic       last_q, last_nxt;
    logic       first_q, first_nxt;
    logic       cnt_inc, cnt_clr, at_max;
    logic       in_acc, out_acc;

    assign in_acc  = in_valid & in_ready;
    assign out_acc = out_valid & out_ready;

    compress_dict_cnt #(
        .DICT_W    (DICT_W),
        .FIRST_FREE(FIRST_FREE)
    ) u_dict_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .cnt   (dict_cnt),
        .at_max(at_max)
    );

    always_comb begin
        nxt       = state;
        probe_nxt = probe_cnt;
        last_nxt  = last_q;
        first_nxt = first_q;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    nxt       = S_LOAD;
                    first_nxt = 1'b1;
                    last_nxt  = 1'b0;
                end
            end
            S_LOAD: begin
                if (in_acc) begin
                    nxt       = S_HASH;
                    last_nxt  = in_last;
                    first_nxt = 1'b0;
                end
            end
            S_HASH: begin
                nxt       = S_PROBE;
                probe_nxt = 4'd0;
            end
            S_PROBE: begin
                if (lk_done) begin
                    if (lk_hit) begin
                        nxt = last_q ? S_FLUSH : S_LOAD;
                    end else begin
                        probe_nxt = probe_cnt + 4'd1;
                        if (probe_cnt + 4'd1 == 4'(PROBE_MAX)) begin
                            nxt = S_EMIT;
                        end
                    end
                end
            end
            S_EMIT: begin
                if (out_acc) begin
                    nxt = S_INSERT;
                end
            end
            S_INSERT: begin
                // A full dictionary is not wrapped; it is flushed with an explicit clear code.
                if (at_max) begin
                    nxt = S_CLEAR;
                end else begin
                    cnt_inc = 1'b1;
                    nxt     = last_q ? S_FLUSH : S_LOAD;
                end
            end
            S_CLEAR: begin
                if (out_acc) begin
                    cnt_clr = 1'b1;
                    nxt     = last_q ? S_FLUSH : S_LOAD;
                end
            end
            S_FLUSH: begin
                if (out_acc) begin
                    nxt = S_DONE;
                end
            end
            S_DONE: begin
                nxt = S_IDLE;
            end
            default: begin
                nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            probe_cnt <= 4'd0;
            last_q    <= 1'b0;
            first_q   <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ctl_code  <= CODE_W'(C_IDLE);
        end else begin
            state     <= nxt;
            probe_cnt <= probe_nxt;
            last_q    <= last_nxt;
            first_q   <= first_nxt;
            in_ready  <= (nxt == S_LOAD);
            out_valid <= (nxt == S_EMIT) || (nxt == S_CLEAR) || (nxt == S_FLUSH);
            busy      <= (nxt != S_IDLE);
            done      <= (nxt == S_DONE);
            ctl_code  <= CODE_W'(code_of(nxt, first_nxt));
        end
    end

endmodule

// File: tb/tb_compress_seq.sv
// Bench for compress_seq: reset, table-driven blocks, hand-timed corner sequences, random blocks.
module tb_compress_seq;
    import compress_pkg::*;

    localparam int DW   = 9;
    localparam int PM   = 4;
    localparam int FF   = 257;
    localparam int MAXD = 511;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, in_valid, in_last, in_ready;
    logic          lk_done, lk_hit, out_valid, out_ready;
    logic [6:0]    ctl_code;
    logic [DW-1:0] dict_cnt;
    logic          busy, done;

    int total = 0;
    int bad   = 0;
    int m_dict = FF;
    int plan_q[$];
    int exp_q[$];

    always #5 clk = ~clk;

    compress_seq #(
        .CODE_W    (7),
        .DICT_W    (DW),
        .FIRST_FREE(FF),
        .PROBE_MAX (PM)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .lk_done  (lk_done),
        .lk_hit   (lk_hit),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ctl_code (ctl_code),
        .dict_cnt (dict_cnt),
        .busy     (busy),
        .done     (done)
    );

    typedef struct {
        int nsym;
        int hit_at;     // probe number that hits, 0 = every probe misses
        int exp_emit;
        int exp_probe;
        int exp_dict;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        start = 0; in_valid = 0; in_last = 0;
        lk_done = 0; lk_hit = 0; out_ready = 0;
    endtask

    // Reference model: per symbol, a full miss emits a code and inserts one entry;
    // inserting into a full dictionary produces a clear code and restarts at FF.
    task automatic build(input int nsym, input bit all_miss, output int probes);
        int h;
        plan_q.delete();
        exp_q.delete();
        probes = 0;
        for (int s = 0; s < nsym; s++) begin
            h = all_miss ? 0 : int'($urandom_range(0, PM));
            plan_q.push_back(h);
            probes += (h == 0) ? PM : h;
            if (h == 0) begin
                exp_q.push_back(int'(C_EMIT));
                if (m_dict == MAXD) begin
                    exp_q.push_back(int'(C_CLEAR));
                    m_dict = FF;
                end else begin
                    m_dict++;
                end
            end
        end
        exp_q.push_back(int'(C_FLUSH));
    endtask

    // Protocol-level driver for one block with random stalls on every handshake.
    task automatic do_block(input int nsym, input bit chk_codes,
                            output int n_acc, output int n_emit, output int n_done,
                            output int n_probe, output int n_clash);
        int  sym, cur, pi, cyc;
        bit  fin;
        sym = 0; cur = 0; pi = 0; cyc = 0; fin = 0;
        n_acc = 0; n_emit = 0; n_done = 0; n_probe = 0; n_clash = 0;
        idle_in();
        start = 1;
        tick();
        start = 0;
        while (!fin && cyc < 300 * nsym + 200) begin
            if (done) begin
                n_done++;
                fin = 1;
            end
            if (in_ready && out_valid) n_clash++;
            idle_in();
            if (in_ready && $urandom_range(0, 3) != 0) begin
                in_valid = 1;
                in_last  = (sym == nsym - 1);
                cur = sym;
                sym++;
                pi = 0;
                n_acc++;
            end
            if (ctl_code == C_PROBE && $urandom_range(0, 3) != 0) begin
                lk_done = 1;
                lk_hit  = (plan_q[cur] == pi + 1);
                pi++;
                n_probe++;
            end
            if (out_valid && $urandom_range(0, 2) != 0) begin
                out_ready = 1;
                if (ctl_code == C_EMIT) n_emit++;
                if (chk_codes) begin
                    if (exp_q.size() != 0) chk("out_code", int'(ctl_code), exp_q.pop_front());
                    else chk("out_code_extra", int'(ctl_code), -1);
                end
            end
            if (!fin) begin
                tick();
                cyc++;
            end
        end
        idle_in();
        if (!fin) chk("block_timeout", 0, 1);
        if (chk_codes) chk("codes_left", exp_q.size(), 0);
        tick();
    endtask

    int acc, emit, dn, prb, clash, probes, w, emit_seen, n;
    int got6[16];
    int exp6[16];

    initial begin
        tbl[0] = '{nsym: 3, hit_at: 1, exp_emit: 0, exp_probe: 3,  exp_dict: 257};
        tbl[1] = '{nsym: 1, hit_at: 0, exp_emit: 1, exp_probe: 4,  exp_dict: 258};
        tbl[2] = '{nsym: 2, hit_at: 4, exp_emit: 0, exp_probe: 8,  exp_dict: 258};
        tbl[3] = '{nsym: 4, hit_at: 0, exp_emit: 4, exp_probe: 16, exp_dict: 262};
        tbl[4] = '{nsym: 2, hit_at: 2, exp_emit: 0, exp_probe: 4,  exp_dict: 262};
        exp6 = '{int'(C_FIRST), int'(C_HASH), int'(C_PROBE), int'(C_PROBE), int'(C_PROBE),
                 int'(C_PROBE), int'(C_EMIT), int'(C_EMIT), int'(C_EMIT), int'(C_EMIT),
                 int'(C_EMIT), int'(C_EMIT), int'(C_INSERT), int'(C_FLUSH), int'(C_IDLE),
                 int'(C_IDLE)};

        idle_in();
        rst_n = 0;
        tick();
        tick();
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ctl", int'(ctl_code), int'(C_IDLE));
        chk("rst_dict", int'(dict_cnt), FF);
        rst_n = 1;
        tick();

        // Table-driven blocks.
        for (int r = 0; r < 5; r++) begin
            plan_q.delete();
            for (int s = 0; s < tbl[r].nsym; s++) plan_q.push_back(tbl[r].hit_at);
            do_block(tbl[r].nsym, 1'b0, acc, emit, dn, prb, clash);
            chk($sformatf("tbl%0d_acc", r), acc, tbl[r].nsym);
            chk($sformatf("tbl%0d_emit", r), emit, tbl[r].exp_emit);
            chk($sformatf("tbl%0d_probe", r), prb, tbl[r].exp_probe);
            chk($sformatf("tbl%0d_done", r), dn, 1);
            chk($sformatf("tbl%0d_clash", r), clash, 0);
            chk($sformatf("tbl%0d_dict", r), int'(dict_cnt), tbl[r].exp_dict);
        end
        m_dict = 262;

        // start during HASH and lk_done during LOAD are ignored.
        idle_in();
        start = 1;
        tick();
        start = 0; lk_done = 1; lk_hit = 1;
        tick();
        chk("ign_lk_ctl", int'(ctl_code), int'(C_FIRST));
        chk("ign_lk_rdy", int'(in_ready), 1);
        tick();
        chk("ign_lk_ctl2", int'(ctl_code), int'(C_FIRST));
        lk_done = 0; lk_hit = 0; in_valid = 1; in_last = 1;
        tick();
        chk("ign_hash_ctl", int'(ctl_code), int'(C_HASH));
        in_valid = 0; in_last = 0; start = 1;
        tick();
        chk("ign_start_ctl", int'(ctl_code), int'(C_PROBE));
        start = 0; lk_done = 1; lk_hit = 1;
        tick();
        chk("ign_flush_ctl", int'(ctl_code), int'(C_FLUSH));
        chk("ign_flush_ov", int'(out_valid), 1);
        lk_done = 0; lk_hit = 0; out_ready = 1;
        tick();
        chk("ign_done", int'(done), 1);
        out_ready = 0;
        tick();
        chk("ign_done_low", int'(done), 0);
        chk("ign_busy_low", int'(busy), 0);
        chk("ign_dict", int'(dict_cnt), m_dict);

        // Single last symbol, four misses, EMIT back-pressured for five cycles.
        idle_in();
        start = 1;
        tick();
        start = 0;
        emit_seen = 0;
        dn = 0;
        for (int k = 0; k < 16; k++) begin
            got6[k] = int'(ctl_code);
            if (done) dn++;
            in_valid = 1; in_last = 1; lk_done = 1; lk_hit = 0;
            if (ctl_code == C_EMIT) begin
                out_ready = (emit_seen >= 5);
                emit_seen++;
            end else begin
                out_ready = 1;
            end
            tick();
        end
        idle_in();
        for (int k = 0; k < 16; k++) chk($sformatf("seq6_code%0d", k), got6[k], exp6[k]);
        chk("seq6_done_cycles", dn, 1);
        m_dict++;
        chk("seq6_dict", int'(dict_cnt), m_dict);

        // Asynchronous reset while a code is pending in EMIT.
        idle_in();
        start = 1;
        tick();
        start = 0; in_valid = 1;
        tick();
        in_valid = 0; lk_done = 1; lk_hit = 0;
        w = 0;
        while (!out_valid && w < 40) begin
            tick();
            w++;
        end
        chk("rst1_emit_code", int'(ctl_code), int'(C_EMIT));
        chk("rst1_emit_ov", int'(out_valid), 1);
        lk_done = 0;
        rst_n = 0;
        #2;
        chk("rst1_ov", int'(out_valid), 0);
        chk("rst1_busy", int'(busy), 0);
        chk("rst1_ctl", int'(ctl_code), int'(C_IDLE));
        chk("rst1_dict", int'(dict_cnt), FF);
        @(negedge clk);
        rst_n = 1;
        tick();
        chk("rst1_done", int'(done), 0);
        chk("rst1_busy2", int'(busy), 0);
        m_dict = FF;

        // Random blocks against the reference model.
        for (int b = 0; b < 6; b++) begin
            n = $urandom_range(1, 6);
            build(n, 1'b0, probes);
            do_block(n, 1'b1, acc, emit, dn, prb, clash);
            chk($sformatf("rnd%0d_acc", b), acc, n);
            chk($sformatf("rnd%0d_probe", b), prb, probes);
            chk($sformatf("rnd%0d_done", b), dn, 1);
            chk($sformatf("rnd%0d_clash", b), clash, 0);
            chk($sformatf("rnd%0d_dict", b), int'(dict_cnt), m_dict);
        end

        // Fill the dictionary to the top so one insert must become a clear.
        n = MAXD - m_dict + 2;
        build(n, 1'b1, probes);
        do_block(n, 1'b1, acc, emit, dn, prb, clash);
        chk("clr_acc", acc, n);
        chk("clr_emit", emit, n);
        chk("clr_done", dn, 1);
        chk("clr_dict", int'(dict_cnt), m_dict);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
